// File: rtl/io_pkg.sv
// Shared constants for the board I/O controller: timing defaults and the hex-to-segment table.
// Table entries are active-low {dp,g,f,e,d,c,b,a}, with the decimal point held off.
package io_pkg;

   localparam int DEB_CYCLES_DEF  = 1000000;
   localparam int SCAN_CYCLES_DEF = 100000;

   // Entry 0 is the last element of the concatenation.
   localparam logic [15:0][7:0] SEG_TABLE = {
      8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
      8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
   };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational. Backpressure: none.
module seg7_decode
   import io_pkg::*;
(
   input  logic [3:0] hex,
   output logic [7:0] seg
);

   assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/io_ctrl.sv
// Board I/O: switch synchronizer and debouncer, LED register, 8-digit multiplexed display.
// Latency: switches 2 + DEB_CYCLES+1 edges, LEDs 1 edge, display 1 edge. Backpressure: none.
module io_ctrl
   import io_pkg::*;
#(
   parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
   parameter int SCAN_CYCLES = SCAN_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        led_ctrl,
   input  logic        seg_ctrl,
   input  logic [31:0] w_dat,
   input  logic [15:0] sw_in,
   output logic [15:0] r_io_dat,
   output logic [15:0] led,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat
);

   localparam int DW = (DEB_CYCLES > 1)  ? $clog2(DEB_CYCLES)  : 1;
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_CYCLES - 1);

   logic [15:0]   sync1, sync2;
   logic [15:0]   cand;
   logic [15:0]   stable;
   logic [DW-1:0] deb_cnt;
   logic [31:0]   seg_val;
   logic [SW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [3:0]    nib;
   logic [7:0]    cat_dec;

   // One shared counter: any bit moving restarts the stability window for all bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= '0;
         sync2   <= '0;
         cand    <= '0;
         stable  <= '0;
         deb_cnt <= '0;
      end else begin
         sync1 <= sw_in;
         sync2 <= sync1;
         if (sync2 != cand) begin
            cand    <= sync2;
            deb_cnt <= '0;
         end else begin
            if (deb_cnt != DEB_MAX)
               deb_cnt <= deb_cnt + 1'b1;
            else
               stable <= cand;
         end
      end
   end

   assign r_io_dat = stable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led     <= '0;
         seg_val <= '0;
      end else begin
         if (led_ctrl)
            led <= w_dat[15:0];
         if (seg_ctrl)
            seg_val <= w_dat;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_MAX) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   assign nib = seg_val[{idx, 2'b00} +: 4];

   seg7_decode u_dec (
      .hex (nib),
      .seg (cat_dec)
   );

   // Registered drive keeps anode and cathode changes on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_an  <= 8'hFF;
         seg_cat <= 8'hFF;
      end else begin
         seg_an  <= ~(8'b1 << idx);
         seg_cat <= cat_dec;
      end
   end

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl with short debounce and scan periods.
module tb_io_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        led_ctrl;
   logic        seg_ctrl;
   logic [31:0] w_dat;
   logic [15:0] sw_in;
   logic [15:0] r_io_dat;
   logic [15:0] led;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;

   int n_checks = 0;
   int n_fail   = 0;

   io_ctrl #(.DEB_CYCLES(4), .SCAN_CYCLES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .led_ctrl (led_ctrl),
      .seg_ctrl (seg_ctrl),
      .w_dat    (w_dat),
      .sw_in    (sw_in),
      .r_io_dat (r_io_dat),
      .led      (led),
      .seg_an   (seg_an),
      .seg_cat  (seg_cat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        l;
      logic        s;
      logic [31:0] w;
      logic [15:0] exp_led;
   } led_vec_t;

   typedef struct {
      logic [7:0] an;
      logic [7:0] cat;
   } disp_t;

   led_vec_t    vecs [5];
   logic [7:0]  hex_seg [16];
   disp_t       sb [$];
   logic [15:0] rd_q [$];
   logic [31:0] seg_model;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_an(input logic [7:0] target, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (seg_an == target) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL wait_an: got %h expected %h within %0d cycles", seg_an, target, budget);
      end
   endtask

   task automatic align_digit0;
      wait_an(8'h7F, 40);
      wait_an(8'hFE, 40);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rd"},  32'(r_io_dat), 32'h0);
      check({tag, "_led"}, 32'(led),      32'h0);
      check({tag, "_an"},  32'(seg_an),   32'hFF);
      check({tag, "_cat"}, 32'(seg_cat),  32'hFF);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      disp_t       e;
      logic [7:0]  one;
      logic [3:0]  n;

      hex_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      vecs[0] = '{1'b1, 1'b0, 32'hDEAD_1234, 16'h1234};
      vecs[1] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 16'h1234};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_ABCD, 16'hABCD};
      vecs[3] = '{1'b0, 1'b1, 32'h0123_89AF, 16'hABCD};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 16'hABCD};
      seg_model = 32'h0;
      one = 8'h01;

      // Reset with all switches high
      rst = 1'b1; led_ctrl = 1'b0; seg_ctrl = 1'b0; w_dat = '0; sw_in = 16'hFFFF;
      repeat (3) tick();
      check_reset_outputs("rst");
      rst = 1'b0; sw_in = 16'h0000;
      tick();
      check("first_an", 32'(seg_an), 32'hFE);
      check("first_cat", 32'(seg_cat), 32'hC0);
      repeat (8) tick();

      // Two-cycle glitch must not reach the stable register
      sw_in = 16'h0001;
      tick(); tick();
      sw_in = 16'h0000;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("glitch_rd", 32'(r_io_dat), 32'h0);
      end

      // Clean change: visible on the 7th edge, not before
      sw_in = 16'h00A5;
      for (int k = 1; k <= 7; k++) rd_q.push_back((k < 7) ? 16'h0000 : 16'h00A5);
      while (rd_q.size() > 0) begin
         tick();
         check("deb_rd", 32'(r_io_dat), 32'(rd_q.pop_front()));
      end

      // LED / seg register writes
      for (int i = 0; i < 5; i++) begin
         led_ctrl = vecs[i].l; seg_ctrl = vecs[i].s; w_dat = vecs[i].w;
         if (vecs[i].s) seg_model = vecs[i].w;
         tick();
         check("led_vec", 32'(led), 32'(vecs[i].exp_led));
      end
      led_ctrl = 1'b0; seg_ctrl = 1'b0;

      // Scan scoreboard: two full passes plus the wrap into digit 0
      align_digit0();
      for (int p = 0; p < 3; p++) begin
         for (int d = 0; d < 8; d++) begin
            if (p < 2 || d == 0) begin
               n = seg_model[4*d +: 4];
               e.an  = ~(one << d);
               e.cat = hex_seg[n];
               sb.push_back(e);
               sb.push_back(e);
            end
         end
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check("scan_an", 32'(seg_an), 32'(e.an));
         check("scan_cat", 32'(seg_cat), 32'(e.cat));
         tick();
      end

      // Both strobes in one cycle
      led_ctrl = 1'b1; seg_ctrl = 1'b1; w_dat = 32'h0000_0005;
      tick();
      led_ctrl = 1'b0; seg_ctrl = 1'b0;
      check("both_led", 32'(led), 32'h0005);
      align_digit0();
      check("both_cat0", 32'(seg_cat), 32'h92);
      tick(); tick();
      check("both_an1", 32'(seg_an), 32'hFD);
      check("both_cat1", 32'(seg_cat), 32'hC0);

      // Reset with debounce counter at 2
      sw_in = 16'h00FF;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_deb");
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 1) check("rst_deb_an", 32'(seg_an), 32'hFE);
         check("rst_deb_rd", 32'(r_io_dat), (k < 7) ? 32'h0 : 32'h00FF);
      end

      // Reset mid-scan at digit 5, with strobes held during reset
      wait_an(8'hDF, 40);
      rst = 1'b1; led_ctrl = 1'b1; seg_ctrl = 1'b1; w_dat = 32'hFFFF_FFFF;
      #1;
      check_reset_outputs("rst_scan");
      tick();
      check("rst_strobe_led", 32'(led), 32'h0);
      led_ctrl = 1'b0; seg_ctrl = 1'b0; rst = 1'b0;
      tick();
      check("rst_scan_an0", 32'(seg_an), 32'hFE);
      check("rst_scan_cat0", 32'(seg_cat), 32'hC0);
      tick(); tick();
      check("rst_scan_an1", 32'(seg_an), 32'hFD);
      check("rst_scan_led", 32'(led), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
